// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The FSM state type is also used by the debug state output.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done bus between a controller (master) and the multiplier (slave).
// Handshake: start is taken only while the multiplier is idle. Operands are captured on that
// edge, and done pulses for exactly one cycle when product holds the new result.
interface seq_multiplier_if
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, done
    );

endinterface

// File: rtl/seq_mult_datapath.sv
// Shift registers, accumulator, single adder and iteration counter for the multiplier.
// load primes the registers; each step performs one shift-and-add iteration.
module seq_mult_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   sum,
    output logic                 last
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mlier;
    logic [CW-1:0]      cnt;

    // sum is the accumulator after the current iteration, so the final product can be
    // captured on the same edge as the last add.
    assign sum  = acc + (mlier[0] ? mcand : '0);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand <= '0;
            mlier <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mlier <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= sum;
            mcand <= mcand << 1;
            mlier <= mlier >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned sequential multiplier: IDLE/RUN/DONE control, product register and done decode.
// Fixed latency of WIDTH iterations; start outside IDLE is ignored.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    seq_multiplier_if.slave bus,
    output state_t          dbg_state
);

    state_t             state_q;
    state_t             state_d;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] sum;

    seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a     (bus.multiplicand),
        .b     (bus.multiplier),
        .sum   (sum),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // product only moves at completion, so the previous result stays visible during a run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.product <= '0;
        end else if (state_q == RUN && last) begin
            bus.product <= sum;
        end
    end

    assign bus.done  = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and sweep stimulus for seq_multiplier with a product/latency scoreboard.
// A negedge monitor pops expectations whenever done is seen.
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    localparam int W = 4;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // scoreboard state
    logic [2*W-1:0] exp_q[$];
    int             edge_q[$];
    int             errors   = 0;
    int             checks   = 0;
    int             done_cnt = 0;
    logic [2*W-1:0] last_result = '0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: product=%0d, expected no done (edge %0d)",
                         bus.product, edge_cnt);
            end else begin
                logic [2*W-1:0] e;
                int             ee;
                e  = exp_q.pop_front();
                ee = edge_q.pop_front();
                check("product", int'(bus.product), int'(e));
                check("done_latency_edge", edge_cnt, ee);
            end
        end
    end

    // drivers
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input bit track);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        if (track) begin
            exp_q.push_back(exp);
            edge_q.push_back(edge_cnt + 1 + W);
        end
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = W'($urandom_range(0, (1 << W) - 1));
        bus.multiplier   = W'($urandom_range(0, (1 << W) - 1));
    endtask

    task automatic wait_done(input logic [2*W-1:0] hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("hold_product", int'(bus.product), int'(hold));
            end
        end
        check("done_seen", int'(seen), 1);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        reset            = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_product", int'(bus.product), 0);
        check("reset_done", int'(bus.done), 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_product", int'(bus.product), 0);
        check("post_reset_done", int'(bus.done), 0);
        check("post_reset_state", int'(dbg_state), int'(IDLE));

        // 3*5
        start_op(4'd3, 4'd5, 8'd15, 1'b1);
        wait_done(8'd0);
        // back-to-back 15*15, old result must be held during the run
        start_op(4'd15, 4'd15, 8'd225, 1'b1);
        wait_done(8'd15);
        // zero operands, full latency, single done each
        start_op(4'd10, 4'd0, 8'd0, 1'b1);
        wait_done(8'd225);
        repeat (8) @(negedge clk);
        check("done_count_zero_a", done_cnt, 3);
        start_op(4'd0, 4'd9, 8'd0, 1'b1);
        wait_done(8'd0);

        // start while busy is dropped
        start_op(4'd3, 4'd5, 8'd15, 1'b1);
        @(negedge clk);
        check("busy_hold_product", int'(bus.product), 0);
        bus.start        = 1'b1;
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(8'd0);
        repeat (10) @(negedge clk);
        check("done_count_busy", done_cnt, 5);
        check("busy_final_product", int'(bus.product), 15);

        // reset mid-run of 12*11
        start_op(4'd12, 4'd11, 8'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_product", int'(bus.product), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_state", int'(dbg_state), int'(IDLE));
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("done_count_abort", done_cnt, 5);
        start_op(4'd12, 4'd11, 8'd132, 1'b1);
        wait_done(8'd0);
        last_result = 8'd132;

        // exhaustive sweep against a*b
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                start_op(W'(a), W'(b), (2*W)'(a * b), 1'b1);
                wait_done(last_result);
                last_result = (2*W)'(a * b);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count_total", done_cnt, 6 + (1 << (2 * W)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
